// File: rtl/cp_insert_ctrl.sv
// Cyclic-prefix scheduler: buffers whole OFDM symbols in a two-bank ping-pong store
// and replays each one as its last CP_LEN samples followed by all SYM_LEN samples.
module cp_insert_ctrl #(
    parameter int DATA_W  = 8,
    parameter int SYM_LEN = 16,
    parameter int CP_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_phase,
    input  logic [DATA_W-1:0] in_quad,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_phase,
    output logic [DATA_W-1:0] out_quad,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_cp,
    output logic              out_sof,
    output logic              out_eof,
    output logic [15:0]       sym_count
);
    localparam int IDX_W = $clog2(SYM_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM_LEN - 1);
    localparam logic [IDX_W-1:0] CP_START = IDX_W'(SYM_LEN - CP_LEN);

    typedef enum logic [1:0] {IDLE, CP, BODY} rd_state_e;

    logic [2*DATA_W-1:0] mem_q [2][SYM_LEN];

    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             in_ready_q, in_ready_d;
    logic             wr_fire, wr_done;

    rd_state_e        state_q, state_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic             out_valid_q, out_valid_d;
    logic             out_cp_q, out_cp_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eof_q, out_eof_d;
    logic [15:0]      sym_count_q, sym_count_d;
    logic [DATA_W-1:0] out_phase_q, out_quad_q;

    logic             beat_taken, rd_done, load_data;
    logic             rd_sel_bank;
    logic [IDX_W-1:0] rd_sel_idx;
    logic [2*DATA_W-1:0] rd_word;

    assign wr_fire = in_valid && in_ready_q;
    assign wr_done = wr_fire && (wr_idx_q == LAST_IDX);

    // NOTE: the sample store has no reset; its contents are never read before
    // the matching full flag is set, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_idx_q] <= {in_phase, in_quad};
        end
    end

    assign rd_word = mem_q[rd_sel_bank][rd_sel_idx];

    // Clear and set target different banks whenever both fire in one cycle.
    always_comb begin
        full_d = full_q;
        if (rd_done) full_d[rd_bank_q] = 1'b0;
        if (wr_done) full_d[wr_bank_q] = 1'b1;
        wr_idx_d   = wr_fire ? wr_idx_q + 1'b1 : wr_idx_q;
        wr_bank_d  = wr_done ? ~wr_bank_q : wr_bank_q;
        in_ready_d = ~full_d[wr_bank_d];
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        out_valid_d = out_valid_q;
        out_cp_d    = out_cp_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        sym_count_d = sym_count_q;
        rd_done     = 1'b0;
        load_data   = 1'b0;
        rd_sel_bank = rd_bank_q;
        rd_sel_idx  = rd_idx_q;
        beat_taken  = out_valid_q && out_ready;

        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d     = CP;
                    rd_idx_d    = CP_START;
                    out_valid_d = 1'b1;
                    out_cp_d    = 1'b1;
                    out_sof_d   = 1'b1;
                    out_eof_d   = 1'b0;
                    load_data   = 1'b1;
                    rd_sel_idx  = CP_START;
                end
            end
            CP: begin
                if (beat_taken) begin
                    out_sof_d = 1'b0;
                    out_eof_d = 1'b0;
                    load_data = 1'b1;
                    if (rd_idx_q == LAST_IDX) begin
                        state_d  = BODY;
                        rd_idx_d = '0;
                        out_cp_d = 1'b0;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                    rd_sel_idx = rd_idx_d;
                end
            end
            BODY: begin
                if (beat_taken) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_done     = 1'b1;
                        rd_bank_d   = ~rd_bank_q;
                        sym_count_d = sym_count_q + 16'd1;
                        // Chain straight into the other bank when it is waiting.
                        if (full_q[~rd_bank_q]) begin
                            state_d     = CP;
                            rd_idx_d    = CP_START;
                            out_cp_d    = 1'b1;
                            out_sof_d   = 1'b1;
                            out_eof_d   = 1'b0;
                            load_data   = 1'b1;
                            rd_sel_bank = rd_bank_d;
                            rd_sel_idx  = CP_START;
                        end else begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                            out_cp_d    = 1'b0;
                            out_sof_d   = 1'b0;
                            out_eof_d   = 1'b0;
                        end
                    end else begin
                        rd_idx_d   = rd_idx_q + 1'b1;
                        out_eof_d  = (rd_idx_d == LAST_IDX);
                        load_data  = 1'b1;
                        rd_sel_idx = rd_idx_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its next-state value from the same pre-edge snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            in_ready_q  <= 1'b0;
            state_q     <= IDLE;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_cp_q    <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            sym_count_q <= '0;
            out_phase_q <= '0;
            out_quad_q  <= '0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            in_ready_q  <= in_ready_d;
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            out_valid_q <= out_valid_d;
            out_cp_q    <= out_cp_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            sym_count_q <= sym_count_d;
            if (load_data) begin
                out_phase_q <= rd_word[2*DATA_W-1:DATA_W];
                out_quad_q  <= rd_word[DATA_W-1:0];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_phase = out_phase_q;
    assign out_quad  = out_quad_q;
    assign out_cp    = out_cp_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign sym_count = sym_count_q;

endmodule

// File: tb/tb_cp_insert_ctrl.sv
// Directed bench for cp_insert_ctrl: single symbol, back-to-back, backpressure,
// input stall, reset mid-output and sym_count wrap.
module tb_cp_insert_ctrl;
    localparam int DATA_W  = 8;
    localparam int SYM_LEN = 16;
    localparam int CP_LEN  = 4;
    localparam int BEATS   = SYM_LEN + CP_LEN;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_phase, in_quad;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_phase, out_quad;
    logic              out_valid;
    logic              out_ready;
    logic              out_cp, out_sof, out_eof;
    logic [15:0]       sym_count;

    int checks = 0;
    int errors = 0;

    // Results of the most recent run_stream call.
    int r_beats, r_bubbles, r_not_ready, r_early, r_t16, r_tfirst;

    always #5 clk = ~clk;

    cp_insert_ctrl #(
        .DATA_W (DATA_W),
        .SYM_LEN(SYM_LEN),
        .CP_LEN (CP_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_phase (in_phase),
        .in_quad  (in_quad),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_phase(out_phase),
        .out_quad (out_quad),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_cp   (out_cp),
        .out_sof  (out_sof),
        .out_eof  (out_eof),
        .sym_count(sym_count)
    );

    // Streams n_syms symbols of samples k=(0,255),(1,254),... and checks every
    // accepted beat. Returns early once beat stop_beat is presented (if >= 0).
    task automatic run_stream(input int n_syms, input bit in_stall, input bit out_toggle,
                              input int stop_beat, input string tag);
        int sent, beats, cyc, s, p, k;
        bit in_ok, held;
        logic [18:0] got, exp, held_snap;
        logic [7:0] eph;
        sent = 0; beats = 0; cyc = 0; held = 1'b0; held_snap = '0;
        r_bubbles = 0; r_not_ready = 0; r_early = 0; r_t16 = -1; r_tfirst = -1;
        while (beats < n_syms * BEATS && cyc < 3000) begin
            if (stop_beat >= 0 && beats == stop_beat && out_valid) begin
                in_valid = 1'b0;
                break;
            end
            if (sent < n_syms * SYM_LEN && (!in_stall || (cyc % 3 == 0))) begin
                in_valid = 1'b1;
                in_phase = 8'(sent);
                in_quad  = 8'(255 - sent);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = out_toggle ? (cyc % 2 == 0) : 1'b1;
            got = {out_phase, out_quad, out_cp, out_sof, out_eof};

            if (held) begin
                checks++;
                if ({out_valid, got[18:1]} !== {1'b1, held_snap[18:1]} || got[0] !== held_snap[0]) begin
                    errors++;
                    $display("FAIL %s stall_hold beat%0d: got %h want %h", tag, beats, got, held_snap);
                end
            end
            held      = out_valid && !out_ready;
            held_snap = got;

            if (!in_ready && sent >= 2 * SYM_LEN && sent < n_syms * SYM_LEN) r_not_ready++;
            if (out_valid && sent < SYM_LEN) r_early++;

            if (out_valid) begin
                if (r_tfirst < 0) r_tfirst = cyc;
                if (out_ready) begin
                    s = beats / BEATS;
                    p = beats % BEATS;
                    k = s * SYM_LEN + ((p < CP_LEN) ? (SYM_LEN - CP_LEN + p) : (p - CP_LEN));
                    eph = 8'(k);
                    exp = {eph, 8'(255 - k), 1'(p < CP_LEN), 1'(p == 0), 1'(p == BEATS - 1)};
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL %s beat%0d {ph,qd,cp,sof,eof}: got %h want %h", tag, beats, got, exp);
                    end
                    beats++;
                end
            end else if (beats > 0 && beats < n_syms * BEATS) begin
                r_bubbles++;
            end

            in_ok = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (in_ok) begin
                sent++;
                if (sent == SYM_LEN) r_t16 = cyc;
            end
            cyc++;
        end
        if (cyc >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d beats want %0d", tag, beats, n_syms * BEATS);
        end
        r_beats   = beats;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_count(input string tag, input logic [15:0] want);
        checks++;
        if (sym_count !== want) begin
            errors++;
            $display("FAIL %s sym_count: got %0d want %0d", tag, sym_count, want);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        logic [36:0] got;
        got = {in_ready, out_valid, out_phase, out_quad, out_cp, out_sof, out_eof, sym_count};
        checks++;
        if (got !== 37'd0) begin
            errors++;
            $display("FAIL %s outputs_zero: got %h want 0", tag, got);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_phase = '0; in_quad = '0; out_ready = 1'b1;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_held");
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release in_ready/out_valid: got %b%b want 10", in_ready, out_valid);
        end
    endtask

    task automatic test_single_symbol();
        run_stream(1, 1'b0, 1'b0, -1, "single");
        checks++;
        if (r_tfirst !== r_t16 + 2) begin
            errors++;
            $display("FAIL single latency: got first-valid cycle %0d want %0d", r_tfirst, r_t16 + 2);
        end
        check_count("single", 16'd1);
    endtask

    task automatic test_back_to_back();
        run_stream(3, 1'b0, 1'b0, -1, "b2b");
        checks++;
        if (r_beats !== 3 * BEATS || r_bubbles !== 0) begin
            errors++;
            $display("FAIL b2b contiguous: got beats %0d bubbles %0d want 60 0", r_beats, r_bubbles);
        end
        checks++;
        if (r_not_ready == 0) begin
            errors++;
            $display("FAIL b2b in_ready_low: got 0 cycles want >0");
        end
        check_count("b2b", 16'd4);
    endtask

    task automatic test_backpressure();
        run_stream(1, 1'b0, 1'b1, -1, "bp");
        check_count("bp", 16'd5);
    endtask

    task automatic test_input_stall();
        run_stream(1, 1'b1, 1'b0, -1, "stall");
        checks++;
        if (r_early !== 0) begin
            errors++;
            $display("FAIL stall early_valid: got %0d cycles want 0", r_early);
        end
        check_count("stall", 16'd6);
    endtask

    task automatic test_reset_mid_output();
        run_stream(1, 1'b0, 1'b0, 7, "mid");
        checks++;
        if (r_beats !== 7 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid reached_beat7: got beats %0d valid %b want 7 1", r_beats, out_valid);
        end
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_stream(1, 1'b0, 1'b0, -1, "after_rst");
        checks++;
        if (r_early !== 0 || r_beats !== BEATS) begin
            errors++;
            $display("FAIL after_rst frame: got early %0d beats %0d want 0 20", r_early, r_beats);
        end
        check_count("after_rst", 16'd1);
    endtask

    task automatic test_wrap();
        force dut.sym_count_q = 16'hFFFF;
        #2;
        release dut.sym_count_q;
        check_count("wrap_preload", 16'hFFFF);
        run_stream(1, 1'b0, 1'b0, -1, "wrap");
        check_count("wrap", 16'd0);
    endtask

    initial begin
        test_reset();
        test_single_symbol();
        test_back_to_back();
        test_backpressure();
        test_input_stall();
        test_reset_mid_output();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
